// File: rtl/ov_cam_dvp_capture_v2.sv
// DVP camera capture: RGB565 / YUV422-luma / RAW8 byte stream to RGB888 frame-buffer writes.
// Optional capture window: define OV_CAM_CROP_EN to add the crop_x0/x1/y0/y1 ports.
module ov_cam_dvp_capture_v2 #(
    parameter int DATA_WIDTH = 8,
    parameter int DVPHO      = 640,
    parameter int DVPVO      = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic [1:0]            mode,
`ifdef OV_CAM_CROP_EN
    input  logic [15:0]           crop_x0,
    input  logic [15:0]           crop_x1,
    input  logic [15:0]           crop_y0,
    input  logic [15:0]           crop_y1,
`endif
    output logic [23:0]           pixel_data_out,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic                  we,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [15:0]           frame_count
);
    localparam logic [1:0]  MODE_RGB565 = 2'b00;
    localparam logic [1:0]  MODE_YUV422 = 2'b01;
    localparam logic [1:0]  MODE_RAW8   = 2'b10;
    localparam logic [31:0] PIX_TOTAL   = 32'(DVPHO * DVPVO);

    typedef enum logic [1:0] {SYNC, WAIT_FRAME, ACTIVE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic                  phase_q, phase_d;
    logic [7:0]            hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [23:0]           pix_q, pix_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           fcnt_q, fcnt_d;

    logic [7:0]  byte_w;
    logic [15:0] rgb_w;
    logic [31:0] next_addr;
    logic        px_vld;
    logic [23:0] px_val;
    logic        px_keep;

`ifdef OV_CAM_CROP_EN
    logic [15:0] cx0_q, cx0_d, cx1_q, cx1_d, cy0_q, cy0_d, cy1_q, cy1_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        href_q;
`endif

    assign pixel_data_out = pix_q;
    assign address_out    = addr_q;
    assign we             = we_q;
    assign frame_done     = done_q;
    assign overflow       = ovf_q;
    assign frame_count    = fcnt_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        phase_d   = phase_q;
        hi_d      = hi_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        pix_d     = pix_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        fcnt_d    = fcnt_q;
        px_vld    = 1'b0;
        px_val    = '0;
        px_keep   = 1'b1;
        byte_w    = d_in[DATA_WIDTH-1 -: 8];
        rgb_w     = {hi_q, byte_w};
        // A write still pending in we_q has not yet been counted into addr_q.
        next_addr = 32'(addr_q) + 32'(we_q);
`ifdef OV_CAM_CROP_EN
        cx0_d   = cx0_q;
        cx1_d   = cx1_q;
        cy0_d   = cy0_q;
        cy1_d   = cy1_q;
        x_d     = x_q;
        y_d     = y_q;
        px_keep = (x_q >= cx0_q) && (x_q <= cx1_q) && (y_q >= cy0_q) && (y_q <= cy1_q);
`endif
        if (we_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        case (state_q)
            SYNC: begin
                if (vsync) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!vsync) begin
                    state_d = ACTIVE;
                    mode_d  = mode;
                    phase_d = 1'b0;
                    addr_d  = '0;
                    ovf_d   = 1'b0;
`ifdef OV_CAM_CROP_EN
                    cx0_d = crop_x0;
                    cx1_d = crop_x1;
                    cy0_d = crop_y0;
                    cy1_d = crop_y1;
                    x_d   = '0;
                    y_d   = '0;
`endif
                end
            end
            ACTIVE: begin
                // Entry needs vsync low, so vsync high here is always its rising edge.
                if (vsync) begin
                    state_d = WAIT_FRAME;
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 16'd1;
                    phase_d = 1'b0;
                end else if (href) begin
                    case (mode_q)
                        MODE_RGB565: begin
                            phase_d = ~phase_q;
                            if (phase_q) begin
                                px_vld = 1'b1;
                                px_val = {rgb_w[15:11], rgb_w[15:13], rgb_w[10:5], rgb_w[10:9],
                                          rgb_w[4:0], rgb_w[4:2]};
                            end else begin
                                hi_d = byte_w;
                            end
                        end
                        MODE_YUV422: begin
                            // Luma is held until its chroma byte so a lone trailing Y is dropped.
                            phase_d = ~phase_q;
                            if (phase_q) begin
                                px_vld = 1'b1;
                                px_val = {hi_q, hi_q, hi_q};
                            end else begin
                                hi_d = byte_w;
                            end
                        end
                        MODE_RAW8: begin
                            px_vld = 1'b1;
                            px_val = {byte_w, byte_w, byte_w};
                        end
                        default: ;
                    endcase
                    if (px_vld) begin
`ifdef OV_CAM_CROP_EN
                        x_d = x_q + 16'd1;
`endif
                        if (px_keep) begin
                            if (next_addr >= PIX_TOTAL) begin
                                ovf_d = 1'b1;
                            end else begin
                                we_d  = 1'b1;
                                pix_d = px_val;
                            end
                        end
                    end
                end else begin
                    phase_d = 1'b0;
`ifdef OV_CAM_CROP_EN
                    x_d = '0;
                    if (href_q) y_d = y_q + 16'd1;
`endif
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SYNC;
            mode_q  <= '0;
            phase_q <= 1'b0;
            hi_q    <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            pix_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            fcnt_q  <= '0;
`ifdef OV_CAM_CROP_EN
            cx0_q  <= '0;
            cx1_q  <= '0;
            cy0_q  <= '0;
            cy1_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            href_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            fcnt_q  <= fcnt_d;
`ifdef OV_CAM_CROP_EN
            cx0_q  <= cx0_d;
            cx1_q  <= cx1_d;
            cy0_q  <= cy0_d;
            cy1_q  <= cy1_d;
            x_q    <= x_d;
            y_q    <= y_d;
            href_q <= href;
`endif
        end
    end
endmodule

// File: tb/tb_ov_cam_dvp_capture_v2.sv
// Bench for ov_cam_dvp_capture_v2 on a small 4x2 frame; builds with or without OV_CAM_CROP_EN.
module tb_ov_cam_dvp_capture_v2;
    localparam int HO    = 4;
    localparam int VO    = 2;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int W     = AW + 24;
    localparam int TOTAL = HO * VO;
    localparam int MAXL  = 3;
    localparam int MAXB  = 12;

    logic           clock = 1'b0;
    logic           reset, vsync, href;
    logic [DW-1:0]  d_in;
    logic [1:0]     mode;
    logic [23:0]    pixel_data_out;
    logic [AW-1:0]  address_out;
    logic           we, frame_done, overflow;
    logic [15:0]    frame_count;
`ifdef OV_CAM_CROP_EN
    logic [15:0]    crop_x0, crop_x1, crop_y0, crop_y1;
`endif

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         exp_frames = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic       exp_ovf;
    int         line_len[MAXL];
    logic [7:0] line_b[MAXL][MAXB];

    always #5 clock = ~clock;

    ov_cam_dvp_capture_v2 #(
        .DATA_WIDTH(DW), .DVPHO(HO), .DVPVO(VO), .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset), .vsync(vsync), .href(href), .d_in(d_in), .mode(mode),
`ifdef OV_CAM_CROP_EN
        .crop_x0(crop_x0), .crop_x1(crop_x1), .crop_y0(crop_y0), .crop_y1(crop_y1),
`endif
        .pixel_data_out(pixel_data_out), .address_out(address_out), .we(we),
        .frame_done(frame_done), .overflow(overflow), .frame_count(frame_count)
    );

    always @(negedge clock) begin
        if (we === 1'b1) obs_q.push_back({address_out, pixel_data_out});
        if (frame_done === 1'b1) done_cnt++;
    end

    function automatic logic [23:0] rgb888(input logic [7:0] hi, input logic [7:0] lo);
        int r5, g6, b5;
        r5 = hi / 8;
        g6 = (hi % 8) * 8 + lo / 32;
        b5 = lo % 32;
        return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
    endfunction

    // Reference: pixels per line from the byte list, linear addresses, stop at TOTAL.
    task automatic model_frame(input logic [1:0] m, input int nl);
        int a, np;
        logic [7:0] hi, lo;
        logic [23:0] px;
        exp_q.delete();
        exp_ovf = 1'b0;
        a = 0;
        for (int l = 0; l < nl; l++) begin
            np = (m == 2'd2) ? line_len[l] : ((m == 2'd3) ? 0 : line_len[l] / 2);
            for (int p = 0; p < np; p++) begin
                if (m == 2'd2) begin
                    hi = line_b[l][p];
                    px = {hi, hi, hi};
                end else if (m == 2'd1) begin
                    hi = line_b[l][2*p];
                    px = {hi, hi, hi};
                end else begin
                    hi = line_b[l][2*p];
                    lo = line_b[l][2*p+1];
                    px = rgb888(hi, lo);
                end
`ifdef OV_CAM_CROP_EN
                if (p < int'(crop_x0) || p > int'(crop_x1) || l < int'(crop_y0) || l > int'(crop_y1)) continue;
`endif
                if (a < TOTAL) begin
                    exp_q.push_back({AW'(a), px});
                    a++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic run_frame(input logic [1:0] m, input logic [1:0] m_mid, input int nl);
        href = 1'b0;
        vsync = 1'b1;
        repeat (3) @(negedge clock);
        mode = m;
        vsync = 1'b0;
        repeat (2) @(negedge clock);
        for (int l = 0; l < nl; l++) begin
            for (int i = 0; i < line_len[l]; i++) begin
                href = 1'b1;
                d_in = line_b[l][i];
                @(negedge clock);
            end
            href = 1'b0;
            d_in = DW'($urandom);
            repeat (2) @(negedge clock);
            mode = m_mid;
        end
        vsync = 1'b1;
        repeat (3) @(negedge clock);
        exp_frames++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vsync = 1'($urandom);
            href = 1'($urandom);
            d_in = DW'($urandom);
            @(negedge clock);
        end
        checks++; if (pixel_data_out !== 24'h0) begin errors++; $display("FAIL reset_pixel got=%h exp=0", pixel_data_out); end
        checks++; if (address_out !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", address_out); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL reset_fcnt got=%h exp=0", frame_count); end
        vsync = 1'b0;
        href = 1'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_partial_frame();
        int d0;
        obs_q.delete();
        d0 = done_cnt;
        mode = 2'd2;
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 4; i++) begin
                href = 1'b1;
                d_in = DW'($urandom);
                @(negedge clock);
            end
            href = 1'b0;
            repeat (2) @(negedge clock);
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL partial_we got=%0d exp=0", obs_q.size()); end
        for (int l = 0; l < 2; l++) begin
            line_len[l] = 4;
            for (int i = 0; i < 4; i++) line_b[l][i] = 8'($urandom);
        end
        run_frame(2'd2, 2'd2, 2);
        model_frame(2'd2, 2);
        checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL raw_count got=%0d exp=8", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL raw_px[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL raw_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL raw_fcnt got=%0d exp=%0d", frame_count, exp_frames); end
    endtask

    task automatic test_rgb565_timing();
        obs_q.delete();
        href = 1'b0;
        vsync = 1'b1;
        repeat (3) @(negedge clock);
        mode = 2'd0;
        vsync = 1'b0;
        repeat (2) @(negedge clock);
        href = 1'b1;
        d_in = 8'hF8;
        @(negedge clock);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rgb_first_we got=%b exp=0", we); end
        d_in = 8'h1F;
        @(negedge clock);
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL rgb_we got=%b exp=1", we); end
        checks++; if (pixel_data_out !== 24'hFF00FF) begin errors++; $display("FAIL rgb_pixel got=%h exp=ff00ff", pixel_data_out); end
        checks++; if (address_out !== '0) begin errors++; $display("FAIL rgb_addr got=%h exp=0", address_out); end
        href = 1'b0;
        @(negedge clock);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rgb_we_width got=%b exp=0", we); end
        checks++; if (address_out !== AW'(1)) begin errors++; $display("FAIL rgb_addr_inc got=%h exp=1", address_out); end
        vsync = 1'b1;
        repeat (3) @(negedge clock);
        exp_frames++;
    endtask

    task automatic test_yuv_luma();
        obs_q.delete();
        line_len[0] = 4;
        line_b[0][0] = 8'h10; line_b[0][1] = 8'h80; line_b[0][2] = 8'h20; line_b[0][3] = 8'h80;
        run_frame(2'd1, 2'd1, 1);
        exp_q.delete();
        exp_q.push_back({AW'(0), 24'h101010});
        exp_q.push_back({AW'(1), 24'h202020});
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL yuv_count got=%0d exp=2", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL yuv_px[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_odd_trailing();
        obs_q.delete();
        line_len[0] = 3;
        line_b[0][0] = 8'hF8; line_b[0][1] = 8'h1F; line_b[0][2] = 8'hAA;
        line_len[1] = 2;
        line_b[1][0] = 8'h00; line_b[1][1] = 8'h1F;
        run_frame(2'd0, 2'd0, 2);
        exp_q.delete();
        exp_q.push_back({AW'(0), 24'hFF00FF});
        exp_q.push_back({AW'(1), 24'h0000FF});
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL odd_count got=%0d exp=2", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL odd_px[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        int d0;
        obs_q.delete();
        line_len[0] = 10;
        for (int i = 0; i < 10; i++) line_b[0][i] = 8'($urandom);
        run_frame(2'd2, 2'd2, 1);
        model_frame(2'd2, 1);
        checks++; if (obs_q.size() != TOTAL) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", obs_q.size(), TOTAL); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_px[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (address_out !== AW'(TOTAL)) begin errors++; $display("FAIL ovf_addr got=%0d exp=%0d", address_out, TOTAL); end
        d0 = done_cnt;
        vsync = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        checks++; if (address_out !== '0) begin errors++; $display("FAIL ovf_addr_clear got=%0d exp=0", address_out); end
        vsync = 1'b1;
        repeat (3) @(negedge clock);
        exp_frames++;
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL empty_done got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_reserved_mode();
        int d0;
        obs_q.delete();
        d0 = done_cnt;
        line_len[0] = 4;
        for (int i = 0; i < 4; i++) line_b[0][i] = 8'($urandom);
        run_frame(2'd3, 2'd3, 1);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rsv_we got=%0d exp=0", obs_q.size()); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rsv_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL rsv_fcnt got=%0d exp=%0d", frame_count, exp_frames); end
    endtask

    task automatic test_mode_change();
        obs_q.delete();
        for (int l = 0; l < 2; l++) begin
            line_len[l] = 4;
            for (int i = 0; i < 4; i++) line_b[l][i] = 8'($urandom);
        end
        run_frame(2'd2, 2'd0, 2);
        model_frame(2'd2, 2);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL mchg_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mchg_px[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_frames();
        int d0, nl;
        logic [1:0] m;
        for (int f = 0; f < 12; f++) begin
            obs_q.delete();
            d0 = done_cnt;
            m = 2'($urandom_range(0, 3));
            nl = $urandom_range(1, MAXL);
            for (int l = 0; l < nl; l++) begin
                line_len[l] = $urandom_range(0, 7);
                for (int i = 0; i < MAXB; i++) line_b[l][i] = 8'($urandom);
            end
            run_frame(m, 2'($urandom_range(0, 3)), nl);
            model_frame(m, nl);
            checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count mode=%0d got=%0d exp=%0d", f, m, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_px[%0d] got=%h exp=%h", f, i, obs_q[i], exp_q[i]); end
            end
            checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rnd%0d_ovf got=%b exp=%b", f, overflow, exp_ovf); end
            checks++; if (address_out !== AW'(exp_q.size())) begin errors++; $display("FAIL rnd%0d_addr got=%0d exp=%0d", f, address_out, exp_q.size()); end
            checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rnd%0d_done got=%0d exp=1", f, done_cnt - d0); end
            checks++; if (frame_count !== 16'(exp_frames)) begin errors++; $display("FAIL rnd%0d_fcnt got=%0d exp=%0d", f, frame_count, exp_frames); end
        end
    endtask

    task automatic test_reset_midframe();
        int d0;
        href = 1'b0;
        vsync = 1'b1;
        repeat (2) @(negedge clock);
        mode = 2'd2;
        vsync = 1'b0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            href = 1'b1;
            d_in = DW'($urandom);
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_frames = 0;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL mid_rst_we got=%b exp=0", we); end
        checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL mid_rst_fcnt got=%0d exp=0", frame_count); end
        checks++; if (address_out !== '0) begin errors++; $display("FAIL mid_rst_addr got=%0d exp=0", address_out); end
        obs_q.delete();
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            d_in = DW'($urandom);
            @(negedge clock);
        end
        href = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_rst_tail_we got=%0d exp=0", obs_q.size()); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL mid_rst_done got=%0d exp=0", done_cnt - d0); end
        line_len[0] = 3;
        for (int i = 0; i < 3; i++) line_b[0][i] = 8'($urandom);
        run_frame(2'd2, 2'd2, 1);
        model_frame(2'd2, 1);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_rst_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_rst_px[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL mid_rst_fcnt1 got=%0d exp=1", frame_count); end
    endtask

`ifdef OV_CAM_CROP_EN
    task automatic test_crop();
        logic [23:0] px1, px2;
        obs_q.delete();
        crop_x0 = 16'd1; crop_x1 = 16'd2; crop_y0 = 16'd0; crop_y1 = 16'd0;
        for (int l = 0; l < 2; l++) begin
            line_len[l] = 4;
            for (int i = 0; i < 4; i++) line_b[l][i] = 8'($urandom);
        end
        px1 = {line_b[0][1], line_b[0][1], line_b[0][1]};
        px2 = {line_b[0][2], line_b[0][2], line_b[0][2]};
        run_frame(2'd2, 2'd2, 2);
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL crop_count got=%0d exp=2", obs_q.size()); end
        if (obs_q.size() >= 2) begin
            checks++; if (obs_q[0] !== {AW'(0), px1}) begin errors++; $display("FAIL crop_px0 got=%h exp=%h", obs_q[0], {AW'(0), px1}); end
            checks++; if (obs_q[1] !== {AW'(1), px2}) begin errors++; $display("FAIL crop_px1 got=%h exp=%h", obs_q[1], {AW'(1), px2}); end
        end
        crop_x0 = 16'd0; crop_x1 = 16'hFFFF; crop_y0 = 16'd0; crop_y1 = 16'hFFFF;
    endtask
`endif

    initial begin
        reset = 1'b1;
        vsync = 1'b0;
        href = 1'b0;
        d_in = '0;
        mode = 2'd0;
`ifdef OV_CAM_CROP_EN
        crop_x0 = 16'd0; crop_x1 = 16'hFFFF; crop_y0 = 16'd0; crop_y1 = 16'hFFFF;
`endif
        test_reset();
        test_partial_frame();
        test_rgb565_timing();
        test_yuv_luma();
        test_odd_trailing();
        test_overflow();
        test_reserved_mode();
        test_mode_change();
        test_random_frames();
`ifdef OV_CAM_CROP_EN
        test_crop();
`endif
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ov_cam_dvp_capture_v2.md
OV_CAM_DVP_CAPTURE_V2 -- requirements
Module: ov_cam_dvp_capture_v2

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_WIDTH, 8, width of d_in (8 or 10; for 10, bits [9:2] are used as the byte).
  DVPHO, 640, active pixels per line.
  DVPVO, 480, active lines per frame.
  ADDR_WIDTH, 19, width of address_out; must satisfy 2^ADDR_WIDTH >= DVPHO*DVPVO.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clock  in  1  the block's single clock, driven by the sensor pixel clock.
  reset  in  1  synchronous, active-high reset.
  vsync  in  1  sensor vsync, high during frame blanking.
  href  in  1  sensor line-valid.
  d_in  in  DATA_WIDTH  sensor data.
  mode  in  2  pixel format: 00 RGB565, 01 YUV422 luma-only, 10 RAW8, 11 reserved.
  pixel_data_out  out  24  pixel as RGB888.
  address_out  out  ADDR_WIDTH  linear frame-buffer address.
  we  out  1  one-cycle write strobe for pixel_data_out and address_out.
  frame_done  out  1  one-cycle pulse at the end of each captured frame.
  overflow  out  1  sticky flag: the frame exceeded DVPHO*DVPVO pixels.
  frame_count  out  16  number of completed frames, wraps modulo 2^16.

Function
REQ-003 All inputs SHALL be sampled on the rising edge of clock; the block SHALL have no other clock.
REQ-004 The FSM SHALL have three states: SYNC, WAIT_FRAME and ACTIVE.
REQ-005 SYNC is the state after reset; in SYNC the block SHALL wait for vsync high and then go to WAIT_FRAME, so a partial frame is never captured.
REQ-006 WAIT_FRAME to ACTIVE SHALL occur on the cycle vsync is sampled low; on that transition mode SHALL be latched, the address reset to 0, the byte phase reset and overflow cleared.
REQ-007 In ACTIVE, a vsync rising edge SHALL end the frame: frame_done pulses one cycle later, frame_count increments by 1, and the state returns to WAIT_FRAME.
REQ-008 RGB565 mode SHALL capture two bytes per pixel, first byte high, and expand each component by replicating its most-significant bits: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-009 YUV422 luma-only mode SHALL use the even-phase bytes (Y) only and output {Y,Y,Y}.
REQ-010 RAW8 mode SHALL treat each byte as one pixel and output {b,b,b}.
REQ-011 we SHALL assert exactly one cycle after the cycle in which the last byte of a pixel is sampled, with pixel_data_out and address_out valid in that same cycle.
REQ-012 address_out SHALL increment by 1 after each we.
REQ-013 The byte phase SHALL reset whenever href is sampled low; an odd trailing byte in RGB565 or YUV422 mode SHALL be discarded.
REQ-014 If a pixel completes when the address is already DVPHO*DVPVO, we SHALL stay low and overflow SHALL set; the address SHALL not wrap.
REQ-015 Reserved mode 11 SHALL capture nothing in that frame (no we), but frame_done and frame_count SHALL still update.
REQ-016 A change on mode during ACTIVE SHALL take effect only from the next frame.

Reset
REQ-017 When reset is high at a clock edge, the outputs SHALL become: pixel_data_out=0, address_out=0, we=0, frame_done=0, overflow=0, frame_count=0.
REQ-018 Reset SHALL also force the FSM to SYNC and clear the byte phase and latched mode, including when asserted mid-line or mid-frame.

Configuration
REQ-019 Macro OV_CAM_CROP_EN, when defined, SHALL add the input ports crop_x0, crop_x1, crop_y0 and crop_y1, each 16 bits.
REQ-020 With OV_CAM_CROP_EN defined, the crop bounds SHALL be latched with mode, and only pixels with crop_x0<=x<=crop_x1 and crop_y0<=y<=crop_y1 SHALL produce we.
REQ-021 With OV_CAM_CROP_EN defined, x SHALL count pixels within a line from 0, y SHALL count lines within the frame from 0, and address_out SHALL count only in-window pixels.
REQ-022 Without OV_CAM_CROP_EN, the crop ports SHALL be absent and every pixel SHALL be written.

Verification
REQ-023 Reset, then a partial frame (href active, no prior vsync), then one full 4x2 RAW8 frame -> no we for the partial frame; 8 we with addresses 0..7; one frame_done; frame_count=1.
REQ-024 RGB565 bytes 0xF8,0x1F -> pixel_data_out=0xFF00FF, delivered one cycle after the second byte.
REQ-025 YUV422 line Y0=0x10,U=0x80,Y1=0x20,V=0x80 -> two we with data 0x101010 and 0x202020.
REQ-026 DVPHO=4, DVPVO=1, six RAW8 bytes in one line -> 4 we at addresses 0..3; overflow=1; address_out holds at 4.
REQ-027 RGB565 line of 3 bytes followed by href low -> 1 we; the trailing byte is discarded; the next line starts at phase 0.
REQ-028 With OV_CAM_CROP_EN, crop 1..2 x 0..0 on a 4x2 RAW8 frame -> exactly 2 we, at addresses 0 and 1, carrying bytes x=1 and x=2.
